// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared widths, redirect classes, FSM states and redirect payload for fetch_redirect_ctrl.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  // Higher encoding wins arbitration and may overwrite a held lower-class redirect.
  typedef enum logic [1:0] {
    CLS_BR   = 2'd0,
    CLS_ERTN = 2'd1,
    CLS_EXC  = 2'd2
  } cls_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] target;
    cls_e            cls;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Flush-source, IF-handshake and pre-IF redirect signals of fetch_redirect_ctrl.
interface fetch_redirect_ctrl_if;

  logic                                         wb_ex;
  logic [fetch_redirect_ctrl_pkg::PC_W-1:0]     ex_entry;
  logic                                         wb_ertn;
  logic [fetch_redirect_ctrl_pkg::PC_W-1:0]     era;
  logic                                         ex_br_taken;
  logic [fetch_redirect_ctrl_pkg::PC_W-1:0]     ex_br_target;
  logic                                         fs_allowin;
  logic                                         br_taken_cancel;
  logic [fetch_redirect_ctrl_pkg::PC_W-1:0]     br_target;
  logic                                         stall;
  logic                                         fs_flush;
  logic [fetch_redirect_ctrl_pkg::CNT_W-1:0]    redirect_cnt;

  // Pipeline side driving requests and observing the redirect.
  modport master (
    output wb_ex, ex_entry, wb_ertn, era, ex_br_taken, ex_br_target, fs_allowin,
    input  br_taken_cancel, br_target, stall, fs_flush, redirect_cnt
  );

  // Controller side.
  modport slave (
    input  wb_ex, ex_entry, wb_ertn, era, ex_br_taken, ex_br_target, fs_allowin,
    output br_taken_cancel, br_target, stall, fs_flush, redirect_cnt
  );

endinterface

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// Combinational 3-way priority selector: exception > ertn > branch.
module fetch_redirect_ctrl_prio_sel
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic            wb_ex,
  input  logic [PC_W-1:0] ex_entry,
  input  logic            wb_ertn,
  input  logic [PC_W-1:0] era,
  input  logic            ex_br_taken,
  input  logic [PC_W-1:0] ex_br_target,
  output logic            req,
  output redirect_t       sel
);

  always_comb begin
    req = wb_ex | wb_ertn | ex_br_taken;
    sel = '{target: '0, cls: CLS_BR};
    if (wb_ex) begin
      sel = '{target: ex_entry, cls: CLS_EXC};
    end else if (wb_ertn) begin
      sel = '{target: era, cls: CLS_ERTN};
    end else if (ex_br_taken) begin
      sel = '{target: ex_br_target, cls: CLS_BR};
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-redirect controller: arbitrates flush sources and holds a redirect until IF can take
// the first fetch of its target, issuing exactly one cancel pulse per redirect.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fetch_redirect_ctrl_if.slave bus
);

  state_e            state, state_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  cls_e              cls_q, cls_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_inc;

  logic              req;
  redirect_t         sel;
  logic              ovr;

  logic              cancel_c;
  logic [PC_W-1:0]   target_c;
  logic              stall_c;
  logic              flush_c;

  fetch_redirect_ctrl_prio_sel u_prio_sel (
    .wb_ex        (bus.wb_ex),
    .ex_entry     (bus.ex_entry),
    .wb_ertn      (bus.wb_ertn),
    .era          (bus.era),
    .ex_br_taken  (bus.ex_br_taken),
    .ex_br_target (bus.ex_br_target),
    .req          (req),
    .sel          (sel)
  );

  // A same-or-higher class request replaces the held redirect; a lower one is dropped.
  assign ovr = req && (sel.cls >= cls_q);

  // Next-state and combinational redirect outputs.
  always_comb begin
    state_d  = state;
    tgt_d    = tgt_q;
    cls_d    = cls_q;
    cnt_inc  = 1'b0;
    cancel_c = 1'b0;
    target_c = '0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (req) begin
          flush_c = 1'b1;
          if (bus.fs_allowin) begin
            cancel_c = 1'b1;
            target_c = sel.target;
            cnt_inc  = 1'b1;
          end else begin
            stall_c = 1'b1;
            tgt_d   = sel.target;
            cls_d   = sel.cls;
            state_d = ST_HOLD;
          end
        end else begin
          stall_c = ~bus.fs_allowin;
        end
      end

      ST_HOLD: begin
        if (ovr) begin
          flush_c = 1'b1;
          tgt_d   = sel.target;
          cls_d   = sel.cls;
        end
        if (bus.fs_allowin) begin
          cancel_c = 1'b1;
          target_c = ovr ? sel.target : tgt_q;
          cnt_inc  = 1'b1;
          state_d  = ST_RUN;
        end else begin
          stall_c = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, held redirect and issue counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      tgt_q <= '0;
      cls_q <= CLS_BR;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      tgt_q <= tgt_d;
      cls_q <= cls_d;
      if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset masks the combinational outputs so pre-IF sees a quiet interface while reset is high.
  assign bus.br_taken_cancel = cancel_c & ~reset;
  assign bus.br_target       = reset ? '0 : target_c;
  assign bus.stall           = stall_c & ~reset;
  assign bus.fs_flush        = flush_c & ~reset;
  assign bus.redirect_cnt    = cnt_q;

endmodule
